dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-ported data memory: one access per 3 cycles.
// Grant/latch in IDLE, memory drive in ACCESS, one-cycle ack/err/rdata pulse in RESP.
module dmem_arbiter #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [2:0]  p0_type,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [2:0]  p1_type,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        mem_write_en,
  output logic [2:0]  s_type,
  output logic [2:0]  l_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  state_t      state_q;
  logic        last_grant_q, gnt_q;
  logic        we_q, err_q;
  logic [2:0]  type_q;
  logic [31:0] addr_q, wdata_q;
  logic        p0_ack_q, p0_err_q, p1_ack_q, p1_err_q;
  logic [31:0] p0_rdata_q, p1_rdata_q;

  logic        win_d, we_d, err_d, active;
  logic [2:0]  type_d;
  logic [31:0] addr_d, wdata_d, rd_d;

  function automatic logic bad_access(input logic we, input logic [2:0] ty, input logic [31:0] a);
    logic bad;
    bad = 1'b0;
    if (we) begin
      case (ty)
        3'b000:  bad = 1'b0;
        3'b001:  bad = a[0];
        3'b010:  bad = (a[1:0] != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (ty)
        3'b000, 3'b100: bad = 1'b0;
        3'b001, 3'b101: bad = a[0];
        3'b010:         bad = (a[1:0] != 2'b00);
        default:        bad = 1'b1;
      endcase
    end
    if (a >= ADDR_LIMIT) bad = 1'b1;
    return bad;
  endfunction

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    win_d   = (p0_req && p1_req) ? ~last_grant_q : p1_req;
    we_d    = win_d ? p1_we    : p0_we;
    type_d  = win_d ? p1_type  : p0_type;
    addr_d  = win_d ? p1_addr  : p0_addr;
    wdata_d = win_d ? p1_wdata : p0_wdata;
    err_d   = bad_access(we_d, type_d, addr_d);
    rd_d    = (err_q || we_q) ? 32'h0 : mem_rdata;
  end

  // Memory side decodes straight from the state register so reset kills the write at once.
  always_comb begin
    active       = (state_q == ACCESS) && !err_q;
    mem_write_en = active && we_q;
    mem_addr     = active ? addr_q  : 32'h0;
    mem_wdata    = active ? wdata_q : 32'h0;
    s_type       = active ? type_q  : 3'b000;
    l_type       = active ? type_q  : 3'b000;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      type_q       <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      err_q        <= 1'b0;
      p0_ack_q     <= 1'b0;
      p0_err_q     <= 1'b0;
      p0_rdata_q   <= 32'h0;
      p1_ack_q     <= 1'b0;
      p1_err_q     <= 1'b0;
      p1_rdata_q   <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (p0_req || p1_req) begin
            state_q      <= ACCESS;
            gnt_q        <= win_d;
            last_grant_q <= win_d;
            we_q         <= we_d;
            type_q       <= type_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
          end
        end
        ACCESS: begin
          state_q    <= RESP;
          p0_ack_q   <= ~gnt_q;
          p0_err_q   <= ~gnt_q & err_q;
          p0_rdata_q <= gnt_q ? 32'h0 : rd_d;
          p1_ack_q   <= gnt_q;
          p1_err_q   <= gnt_q & err_q;
          p1_rdata_q <= gnt_q ? rd_d : 32'h0;
        end
        RESP: begin
          state_q    <= IDLE;
          p0_ack_q   <= 1'b0;
          p0_err_q   <= 1'b0;
          p0_rdata_q <= 32'h0;
          p1_ack_q   <= 1'b0;
          p1_err_q   <= 1'b0;
          p1_rdata_q <= 32'h0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p0_ack   = p0_ack_q;
  assign p0_err   = p0_err_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_ack   = p1_ack_q;
  assign p1_err   = p1_err_q;
  assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses push expected responses, a monitor checks acks.
module tb_dmem_arbiter;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [2:0]  p0_type = 0, p1_type = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_write_en;
  logic [2:0]  s_type, l_type;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [32];
  logic        mem_load = 1'b1;
  exp_t        sb[$];
  int          n_vec = 0, n_bad = 0, wen_cnt = 0, wen_snap;
  int          lat0, lat1;
  logic [31:0] last_waddr = 0, last_wdata = 0;

  dmem_arbiter #(.MEM_WORDS(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_type(p0_type), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_type(p1_type), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_write_en(mem_write_en), .s_type(s_type), .l_type(l_type),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: combinational extended read, byte/half/word write on the clock edge.
  always_comb begin
    logic [31:0] w, b, h;
    w = mem[mem_addr[6:2]];
    b = w >> {mem_addr[1:0], 3'b000};
    h = w >> {mem_addr[1], 4'b0000};
    case (l_type)
      3'b000:  mem_rdata = {{24{b[7]}}, b[7:0]};
      3'b001:  mem_rdata = {{16{h[15]}}, h[15:0]};
      3'b100:  mem_rdata = {24'h0, b[7:0]};
      3'b101:  mem_rdata = {16'h0, h[15:0]};
      default: mem_rdata = w;
    endcase
  end

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[1]  <= 32'hCAFE0001;
      mem[31] <= 32'h77770031;
    end else if (mem_write_en) begin
      case (s_type)
        3'b000:  mem[mem_addr[6:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
        3'b001:  mem[mem_addr[6:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
        default: mem[mem_addr[6:2]] <= mem_wdata;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_resp(input int port, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.port = port; e.err = err; e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; returns cycles from raising req to seeing ack.
  task automatic drive(input int port, input logic we, input logic [2:0] ty,
                       input logic [31:0] a, input logic [31:0] wd, input bit chg, output int lat);
    if (port == 0) begin p0_we = we; p0_type = ty; p0_addr = a; p0_wdata = wd; p0_req = 1'b1; end
    else           begin p1_we = we; p1_type = ty; p1_addr = a; p1_wdata = wd; p1_req = 1'b1; end
    lat = 0;
    forever begin
      @(negedge clk);
      if ((port == 0) ? p0_ack : p1_ack) break;
      lat++;
      if (chg && lat == 2) begin
        if (port == 0) begin p0_addr = 32'h14; p0_wdata = 32'h22222222; end
        else           begin p1_addr = 32'h14; p1_wdata = 32'h22222222; end
      end
      if (lat > 40) begin
        n_vec++; n_bad++;
        $display("FAIL ack_timeout port=%0d got no ack expected ack within 40 cycles", port);
        break;
      end
    end
    @(posedge clk); #1;
    if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_write_en) begin
        wen_cnt++;
        last_waddr = mem_addr;
        last_wdata = mem_wdata;
      end
      if (p0_ack || p1_ack) begin
        if (sb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_ack: got p0_ack=%b p1_ack=%b expected none", p0_ack, p1_ack);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_port", {31'h0, p1_ack}, 32'(e.port));
          chk("ack_both", {31'h0, p0_ack & p1_ack}, 32'h0);
          chk("err", {31'h0, (e.port == 1) ? p1_err : p0_err}, {31'h0, e.err});
          chk("rdata", (e.port == 1) ? p1_rdata : p0_rdata, e.rdata);
          chk("other_rdata", (e.port == 1) ? p0_rdata : p1_rdata, 32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_p0_ack", {31'h0, p0_ack}, 32'h0);
    chk("rst_p1_ack", {31'h0, p1_ack}, 32'h0);
    chk("rst_rdata", p0_rdata | p1_rdata, 32'h0);
    chk("rst_wen", {31'h0, mem_write_en}, 32'h0);
    chk("rst_mem_addr", mem_addr | mem_wdata, 32'h0);
    chk("rst_types", {26'h0, s_type, l_type}, 32'h0);
    mem_load = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous requests: port 0 first, port 1 three cycles later; alternation holds.
    for (int k = 0; k < 2; k++) begin
      expect_resp(0, 1'b0, 32'hCAFE0001);
      expect_resp(1, 1'b0, 32'hCAFE0001);
      fork
        drive(0, 1'b0, 3'b010, 32'h04, 32'h0, 1'b0, lat0);
        drive(1, 1'b0, 3'b010, 32'h04, 32'h0, 1'b0, lat1);
      join
      chk("tie_p0_latency", 32'(lat0), 32'd2);
      chk("tie_p1_latency", 32'(lat1), 32'd5);
    end

    wen_snap = wen_cnt;
    expect_resp(0, 1'b0, 32'h0);
    drive(0, 1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 1'b0, lat0);
    expect_resp(0, 1'b0, 32'hDEADBEEF);
    drive(0, 1'b0, 3'b010, 32'h08, 32'h0, 1'b0, lat0);
    chk("lw_latency", 32'(lat0), 32'd2);
    chk("sw_wen_pulses", 32'(wen_cnt - wen_snap), 32'd1);

    // Rejected accesses: misaligned, out of range, undefined codes. Last word is legal.
    wen_snap = wen_cnt;
    expect_resp(1, 1'b1, 32'h0);
    drive(1, 1'b1, 3'b001, 32'h03, 32'hFFFF, 1'b0, lat1);
    expect_resp(1, 1'b1, 32'h0);
    drive(1, 1'b0, 3'b010, 32'h80, 32'h0, 1'b0, lat1);
    expect_resp(0, 1'b1, 32'h0);
    drive(0, 1'b1, 3'b011, 32'h00, 32'h1, 1'b0, lat0);
    expect_resp(1, 1'b1, 32'h0);
    drive(1, 1'b0, 3'b110, 32'h00, 32'h0, 1'b0, lat1);
    expect_resp(0, 1'b1, 32'h0);
    drive(0, 1'b0, 3'b001, 32'h05, 32'h0, 1'b0, lat0);
    chk("err_no_wen", 32'(wen_cnt - wen_snap), 32'd0);
    expect_resp(1, 1'b0, 32'h77770031);
    drive(1, 1'b0, 3'b010, 32'h7C, 32'h0, 1'b0, lat1);

    expect_resp(0, 1'b0, 32'h0);
    drive(0, 1'b1, 3'b000, 32'h05, 32'h000000F0, 1'b0, lat0);
    expect_resp(0, 1'b0, 32'hFFFFFFF0);
    drive(0, 1'b0, 3'b000, 32'h05, 32'h0, 1'b0, lat0);
    expect_resp(0, 1'b0, 32'h000000F0);
    drive(0, 1'b0, 3'b100, 32'h05, 32'h0, 1'b0, lat0);
    expect_resp(0, 1'b0, 32'hCAFEF001);
    drive(0, 1'b0, 3'b010, 32'h04, 32'h0, 1'b0, lat0);
    expect_resp(1, 1'b0, 32'hFFFFCAFE);
    drive(1, 1'b0, 3'b001, 32'h06, 32'h0, 1'b0, lat1);
    expect_resp(1, 1'b0, 32'h0000CAFE);
    drive(1, 1'b0, 3'b101, 32'h06, 32'h0, 1'b0, lat1);

    // Inputs changed during ACCESS must not reach the memory.
    expect_resp(0, 1'b0, 32'h0);
    drive(0, 1'b1, 3'b010, 32'h0C, 32'h11111111, 1'b1, lat0);
    chk("latched_waddr", last_waddr, 32'h0C);
    chk("latched_wdata", last_wdata, 32'h11111111);
    expect_resp(0, 1'b0, 32'h11111111);
    drive(0, 1'b0, 3'b010, 32'h0C, 32'h0, 1'b0, lat0);
    expect_resp(0, 1'b0, 32'h0);
    drive(0, 1'b0, 3'b010, 32'h14, 32'h0, 1'b0, lat0);

    // Reset in the middle of a port 1 store.
    expect_resp(0, 1'b0, 32'h0);
    drive(0, 1'b1, 3'b010, 32'h10, 32'hAAAA5555, 1'b0, lat0);
    p1_we = 1'b1; p1_type = 3'b010; p1_addr = 32'h10; p1_wdata = 32'h12345678; p1_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("wen_in_access", {31'h0, mem_write_en}, 32'h1);
    #2 reset_n = 1'b0;
    #1 chk("wen_async_drop", {31'h0, mem_write_en}, 32'h0);
    chk("rst_mid_addr", mem_addr, 32'h0);
    p1_req = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    expect_resp(0, 1'b0, 32'hAAAA5555);
    drive(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, lat0);
    chk("post_rst_latency", 32'(lat0), 32'd2);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
